// File: rtl/quad_7_seg_capture.sv
`default_nettype none
// ============================================================================
// Module   : quad_7_seg_capture
// Purpose  : Monitors a scanned 4-digit active-low 7-segment bus, decodes
//            each digit back to a hex nibble and checks the 3-2-1-0 scan order.
// Revision : 1.0 - initial release
// ============================================================================
module quad_7_seg_capture #(
  parameter int STABLE_CYCLES = 1,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg,
  input  logic [3:0] an,
  input  logic       dp,
  input  logic       clear_err,
  output logic [3:0] num3,
  output logic [3:0] num2,
  output logic [3:0] num1,
  output logic [3:0] num0,
  output logic [3:0] dot_out,
  output logic [3:0] digit_valid,
  output logic       frame_done,
  output logic       scan_error
);

  // Encoding equals the digit index the FSM is waiting for.
  typedef enum logic [1:0] {
    EXP0 = 2'd0,
    EXP1 = 2'd1,
    EXP2 = 2'd2,
    EXP3 = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]  c_stable_cnt = CNT_W'(STABLE_CYCLES);
  localparam logic [11:0]       c_blank_smp  = {7'h7F, 4'hF, 1'b1};

  logic [11:0]      w_in;
  logic [11:0]      r_sample;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pending;
  logic             w_commit;
  logic [6:0]       w_seg;
  logic [3:0]       w_an;
  logic             w_dp;
  logic             w_is_blank;
  logic             w_dig_ok;
  logic [1:0]       w_dig;
  logic [4:0]       w_glyph;
  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_err;
  logic             w_frame;
  logic [3:0]       r_num [4];

  // Returns {legal, nibble} for an active-low segment pattern.
  function automatic logic [4:0] glyph_lookup(input logic [6:0] s);
    case (s)
      7'h40:   glyph_lookup = 5'h10;
      7'h79:   glyph_lookup = 5'h11;
      7'h24:   glyph_lookup = 5'h12;
      7'h30:   glyph_lookup = 5'h13;
      7'h19:   glyph_lookup = 5'h14;
      7'h12:   glyph_lookup = 5'h15;
      7'h02:   glyph_lookup = 5'h16;
      7'h78:   glyph_lookup = 5'h17;
      7'h00:   glyph_lookup = 5'h18;
      7'h10:   glyph_lookup = 5'h19;
      7'h08:   glyph_lookup = 5'h1A;
      7'h03:   glyph_lookup = 5'h1B;
      7'h46:   glyph_lookup = 5'h1C;
      7'h21:   glyph_lookup = 5'h1D;
      7'h06:   glyph_lookup = 5'h1E;
      7'h0E:   glyph_lookup = 5'h1F;
      default: glyph_lookup = 5'h00;
    endcase
  endfunction

  assign w_in     = {seg, an, dp};
  assign w_seg    = r_sample[11:5];
  assign w_an     = r_sample[4:1];
  assign w_dp     = r_sample[0];
  assign w_glyph  = glyph_lookup(w_seg);
  // A run commits once: pending is armed by a change and consumed by the commit.
  assign w_commit = r_pending && (r_cnt == c_stable_cnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sample  <= c_blank_smp;
      r_cnt     <= '0;
      r_pending <= 1'b0;
    end else begin
      r_sample <= w_in;
      if (w_in != r_sample) begin
        r_cnt     <= CNT_W'(1);
        r_pending <= 1'b1;
      end else begin
        if (r_cnt < c_stable_cnt) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
        if (w_commit) begin
          r_pending <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_is_blank = (w_an == 4'hF);
    w_dig_ok   = 1'b1;
    w_dig      = 2'd0;
    case (w_an)
      4'b0111: w_dig = 2'd3;
      4'b1011: w_dig = 2'd2;
      4'b1101: w_dig = 2'd1;
      4'b1110: w_dig = 2'd0;
      default: w_dig_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= EXP3;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err       = 1'b0;
    w_frame     = 1'b0;
    if (w_commit) begin
      if (w_dig_ok) begin
        if (w_dig == 2'(r_state)) begin
          if (r_state == EXP0) begin
            w_frame     = 1'b1;
            w_state_nxt = EXP3;
          end else begin
            w_state_nxt = state_t'(2'(r_state) - 2'd1);
          end
        end else begin
          w_err       = 1'b1;
          w_state_nxt = (w_dig == 2'd3) ? EXP2 : EXP3;
        end
      end else if (!w_is_blank) begin
        w_err       = 1'b1;
        w_state_nxt = EXP3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        r_num[i] <= 4'h0;
      end
      dot_out     <= 4'h0;
      digit_valid <= 4'h0;
      frame_done  <= 1'b0;
      scan_error  <= 1'b0;
    end else begin
      frame_done <= w_frame;
      scan_error <= w_err | (scan_error & ~clear_err);
      if (w_commit && w_dig_ok) begin
        r_num[w_dig]       <= w_glyph[3:0];
        dot_out[w_dig]     <= ~w_dp;
        digit_valid[w_dig] <= w_glyph[4];
      end
    end
  end

  assign num3 = r_num[3];
  assign num2 = r_num[2];
  assign num1 = r_num[1];
  assign num0 = r_num[0];

endmodule
`default_nettype wire

// File: tb/tb_quad_7_seg_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_quad_7_seg_capture
// Purpose  : Directed self-checking bench; one DUT with STABLE_CYCLES=1 and
//            one with STABLE_CYCLES=3 share the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_quad_7_seg_capture;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] seg = 7'h7F;
  logic [3:0] an = 4'hF;
  logic       dp = 1'b1;
  logic       clear_err = 1'b0;

  logic [3:0] s1_num3, s1_num2, s1_num1, s1_num0, s1_dot, s1_valid;
  logic       s1_fd, s1_err;
  logic [3:0] s3_num3, s3_num2, s3_num1, s3_num0, s3_dot, s3_valid;
  logic       s3_fd, s3_err;

  int n_cmp = 0;
  int n_bad = 0;
  int fd1 = 0;
  int f0 = 0;

  quad_7_seg_capture #(.STABLE_CYCLES(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .reset(reset), .seg(seg), .an(an), .dp(dp), .clear_err(clear_err),
    .num3(s1_num3), .num2(s1_num2), .num1(s1_num1), .num0(s1_num0),
    .dot_out(s1_dot), .digit_valid(s1_valid), .frame_done(s1_fd), .scan_error(s1_err)
  );

  quad_7_seg_capture #(.STABLE_CYCLES(3), .CNT_W(4)) u_dut3 (
    .clk(clk), .reset(reset), .seg(seg), .an(an), .dp(dp), .clear_err(clear_err),
    .num3(s3_num3), .num2(s3_num2), .num1(s3_num1), .num0(s3_num0),
    .dot_out(s3_dot), .digit_valid(s3_valid), .frame_done(s3_fd), .scan_error(s3_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (s1_fd) fd1++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [6:0] s, input logic [3:0] a, input logic d);
    @(negedge clk);
    seg = s;
    an  = a;
    dp  = d;
  endtask

  task automatic blank();
    drive(7'h7F, 4'hF, 1'b1);
  endtask

  task automatic frame(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                       input logic [6:0] s0, input logic [3:0] d);
    drive(s3, 4'b0111, d[3]);
    drive(s2, 4'b1011, d[2]);
    drive(s1, 4'b1101, d[1]);
    drive(s0, 4'b1110, d[0]);
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_val("rst_nums1", 32'({s1_num3, s1_num2, s1_num1, s1_num0}), 32'h0);
    check_val("rst_misc1", 32'({s1_dot, s1_valid, s1_fd, s1_err}), 32'h0);
    check_val("rst_nums3", 32'({s3_num3, s3_num2, s3_num1, s3_num0}), 32'h0);
    check_val("rst_misc3", 32'({s3_dot, s3_valid, s3_fd, s3_err}), 32'h0);
    reset = 1'b0;

    // Clean rotation 3,5,A,8 with the dot on digit 2
    frame(7'h30, 7'h12, 7'h08, 7'h00, 4'b1011);
    blank();
    check_val("fd_early", 32'(s1_fd), 32'h0);
    @(negedge clk);
    check_val("fd_timing", 32'(s1_fd), 32'h1);
    check_val("nums_clean", 32'({s1_num3, s1_num2, s1_num1, s1_num0}), 32'h35A8);
    check_val("dot_clean", 32'(s1_dot), 32'h4);
    check_val("valid_clean", 32'(s1_valid), 32'hF);
    f0 = fd1;
    frame(7'h30, 7'h12, 7'h08, 7'h00, 4'b1011);
    frame(7'h30, 7'h12, 7'h08, 7'h00, 4'b1011);
    blank();
    blank();
    check_val("fd_count", 32'(fd1 - f0), 32'd2);
    check_val("err_clean", 32'(s1_err), 32'h0);

    // Illegal glyph on digit 2
    f0 = fd1;
    frame(7'h30, 7'h7F, 7'h08, 7'h00, 4'b1011);
    blank();
    blank();
    check_val("nums_badglyph", 32'({s1_num3, s1_num2, s1_num1, s1_num0}), 32'h30A8);
    check_val("valid_badglyph", 32'(s1_valid), 32'hB);
    check_val("err_badglyph", 32'(s1_err), 32'h0);
    check_val("fd_badglyph", 32'(fd1 - f0), 32'd1);

    // Scan order 3,1,2,0
    f0 = fd1;
    drive(7'h30, 4'b0111, 1'b1);
    drive(7'h08, 4'b1101, 1'b1);
    drive(7'h12, 4'b1011, 1'b0);
    check_val("err_before_d1", 32'(s1_err), 32'h0);
    drive(7'h00, 4'b1110, 1'b1);
    check_val("err_at_d1", 32'(s1_err), 32'h1);
    blank();
    blank();
    check_val("fd_suppressed", 32'(fd1 - f0), 32'd0);
    check_val("nums_order", 32'({s1_num3, s1_num2, s1_num1, s1_num0}), 32'h35A8);
    f0 = fd1;
    pulse_clear();
    frame(7'h30, 7'h12, 7'h08, 7'h00, 4'b1011);
    blank();
    blank();
    check_val("err_cleared", 32'(s1_err), 32'h0);
    check_val("fd_resumed", 32'(fd1 - f0), 32'd1);

    // Two anodes low mid-frame
    drive(7'h30, 4'b0111, 1'b1);
    drive(7'h12, 4'b1011, 1'b0);
    drive(7'h79, 4'b0011, 1'b1);
    blank();
    blank();
    check_val("err_bad_an", 32'(s1_err), 32'h1);
    check_val("nums_hold", 32'({s1_num3, s1_num2, s1_num1, s1_num0}), 32'h35A8);
    pulse_clear();
    check_val("err_cleared2", 32'(s1_err), 32'h0);
    f0 = fd1;
    frame(7'h30, 7'h12, 7'h08, 7'h00, 4'b1011);
    blank();
    blank();
    check_val("fd_after_resync", 32'(fd1 - f0), 32'd1);
    check_val("err_after_resync", 32'(s1_err), 32'h0);
    drive(7'h79, 4'b0011, 1'b1);
    blank();
    pulse_clear();
    check_val("err_wins", 32'(s1_err), 32'h1);
    pulse_clear();
    check_val("err_cleared3", 32'(s1_err), 32'h0);

    // Reset after digits 3 and 2 committed
    drive(7'h30, 4'b0111, 1'b1);
    drive(7'h12, 4'b1011, 1'b0);
    blank();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_val("midrst_nums", 32'({s1_num3, s1_num2, s1_num1, s1_num0}), 32'h0);
    check_val("midrst_misc", 32'({s1_dot, s1_valid, s1_fd, s1_err}), 32'h0);
    reset = 1'b0;
    drive(7'h08, 4'b1101, 1'b1);
    blank();
    @(negedge clk);
    check_val("err_after_rst", 32'(s1_err), 32'h1);
    check_val("nums_after_rst", 32'({s1_num3, s1_num2, s1_num1, s1_num0}), 32'h00A0);
    check_val("valid_after_rst", 32'(s1_valid), 32'h2);
    pulse_clear();
    f0 = fd1;
    frame(7'h30, 7'h12, 7'h08, 7'h00, 4'b1011);
    blank();
    blank();
    check_val("fd_after_rst", 32'(fd1 - f0), 32'd1);

    // STABLE_CYCLES=3 filtering
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) drive(7'h24, 4'b1101, 1'b1);
    repeat (4) blank();
    check_val("s3_glitch_nums", 32'({s3_num3, s3_num2, s3_num1, s3_num0}), 32'h0);
    check_val("s3_glitch_valid", 32'(s3_valid), 32'h0);
    repeat (3) drive(7'h24, 4'b1101, 1'b1);
    blank();
    check_val("s3_before", 32'({s3_num3, s3_num2, s3_num1, s3_num0}), 32'h0);
    @(negedge clk);
    check_val("s3_commit", 32'({s3_num3, s3_num2, s3_num1, s3_num0}), 32'h0020);
    check_val("s3_valid", 32'(s3_valid), 32'h2);
    check_val("s3_err_order", 32'(s3_err), 32'h1);
    pulse_clear();
    check_val("s3_err_clr", 32'(s3_err), 32'h0);
    repeat (5) drive(7'h30, 4'b1101, 1'b1);
    clear_err = 1'b1;
    drive(7'h30, 4'b1101, 1'b1);
    clear_err = 1'b0;
    repeat (14) drive(7'h30, 4'b1101, 1'b1);
    check_val("s3_hold_nums", 32'({s3_num3, s3_num2, s3_num1, s3_num0}), 32'h0030);
    check_val("s3_no_recommit", 32'(s3_err), 32'h0);
    check_val("s1_no_recommit", 32'(s1_err), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
